// File: rtl/jump_controller.sv
// jump_controller: turns player presses into one-cycle jump commands, waits for the
// character to land, keeps the saturating score and latches game over.
module jump_controller #(
  parameter int CNT_W        = 26,
  parameter int REACT_CYCLES = 40_000_000,
  parameter int LAND_TIMEOUT = 20_000_000,
  parameter int SCORE_MAX    = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       module_en,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       next_valid,
  input  logic       next_side,
  input  logic       landed,
  output logic       jump_left,
  output logic       jump_right,
  output logic       jump_fail,
  output logic       block_advance,
  output logic       busy,
  output logic [9:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {S_WAIT, S_JUMP, S_FALL, S_OVER} state_t;

  localparam logic [CNT_W-1:0] REACT_LAST = CNT_W'(REACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAND_LAST  = CNT_W'(LAND_TIMEOUT - 1);
  localparam logic [9:0]       SCORE_TOP  = 10'(SCORE_MAX);

  state_t           state_q, state_d;
  logic             btn_left_q, btn_left_d;
  logic             btn_right_q, btn_right_d;
  logic             started_q, started_d;
  logic [CNT_W-1:0] react_cnt_q, react_cnt_d;
  logic [CNT_W-1:0] land_cnt_q, land_cnt_d;
  logic [9:0]       score_q, score_d;
  logic             jump_left_q, jump_left_d;
  logic             jump_right_q, jump_right_d;
  logic             jump_fail_q, jump_fail_d;
  logic             block_advance_q, block_advance_d;
  logic             busy_q, busy_d;
  logic             game_over_q, game_over_d;

  logic clr;
  logic press_l, press_r;

  // Disabling the module is indistinguishable from a reset.
  assign clr = rst | ~module_en;

  assign press_l = btn_left & ~btn_left_q;
  assign press_r = btn_right & ~btn_right_q;

  always_comb begin
    state_d         = state_q;
    btn_left_d      = btn_left;
    btn_right_d     = btn_right;
    started_d       = started_q;
    react_cnt_d     = react_cnt_q;
    land_cnt_d      = land_cnt_q;
    score_d         = score_q;
    jump_left_d     = 1'b0;
    jump_right_d    = 1'b0;
    jump_fail_d     = 1'b0;
    block_advance_d = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (next_valid) begin
          if (press_l && press_r) begin
            jump_fail_d = 1'b1;
            land_cnt_d  = '0;
            state_d     = S_FALL;
          end else if (press_l || press_r) begin
            // A single press is correct when its side matches next_side.
            if (press_r == next_side) begin
              jump_left_d  = press_l;
              jump_right_d = press_r;
              started_d    = 1'b1;
              land_cnt_d   = '0;
              state_d      = S_JUMP;
            end else begin
              jump_fail_d = 1'b1;
              land_cnt_d  = '0;
              state_d     = S_FALL;
            end
          end else if (started_q) begin
            if (react_cnt_q == REACT_LAST) begin
              jump_fail_d = 1'b1;
              land_cnt_d  = '0;
              state_d     = S_FALL;
            end else begin
              react_cnt_d = react_cnt_q + 1'b1;
            end
          end
        end
      end

      S_JUMP: begin
        if (landed) begin
          block_advance_d = 1'b1;
          score_d         = (score_q >= SCORE_TOP) ? score_q : score_q + 10'd1;
          react_cnt_d     = '0;
          state_d         = S_WAIT;
        end else if (land_cnt_q == LAND_LAST) begin
          state_d = S_OVER;
        end else begin
          land_cnt_d = land_cnt_q + 1'b1;
        end
      end

      S_FALL: begin
        if (landed || (land_cnt_q == LAND_LAST)) begin
          state_d = S_OVER;
        end else begin
          land_cnt_d = land_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_OVER;
      end
    endcase

    busy_d      = (state_d == S_JUMP) || (state_d == S_FALL);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q         <= S_WAIT;
      btn_left_q      <= 1'b0;
      btn_right_q     <= 1'b0;
      started_q       <= 1'b0;
      react_cnt_q     <= '0;
      land_cnt_q      <= '0;
      score_q         <= '0;
      jump_left_q     <= 1'b0;
      jump_right_q    <= 1'b0;
      jump_fail_q     <= 1'b0;
      block_advance_q <= 1'b0;
      busy_q          <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      btn_left_q      <= btn_left_d;
      btn_right_q     <= btn_right_d;
      started_q       <= started_d;
      react_cnt_q     <= react_cnt_d;
      land_cnt_q      <= land_cnt_d;
      score_q         <= score_d;
      jump_left_q     <= jump_left_d;
      jump_right_q    <= jump_right_d;
      jump_fail_q     <= jump_fail_d;
      block_advance_q <= block_advance_d;
      busy_q          <= busy_d;
      game_over_q     <= game_over_d;
    end
  end

  assign jump_left     = jump_left_q;
  assign jump_right    = jump_right_q;
  assign jump_fail     = jump_fail_q;
  assign block_advance = block_advance_q;
  assign busy          = busy_q;
  assign score         = score_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_jump_controller.sv
// tb_jump_controller: randomized scenarios for jump_controller; expected output events
// are predicted per transaction and checked by an independent monitor.
module tb_jump_controller;

  localparam int REACT = 100;
  localparam int LAND  = 50;
  localparam int SMAX  = 999;

  localparam logic [2:0] K_JL = 3'd0, K_JR = 3'd1, K_JF = 3'd2, K_ADV = 3'd3, K_OVER = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       module_en = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0;
  logic       next_valid = 1'b0, next_side = 1'b0, landed = 1'b0;
  logic       jump_left, jump_right, jump_fail, block_advance, busy, game_over;
  logic [9:0] score;

  jump_controller #(
    .CNT_W(26), .REACT_CYCLES(REACT), .LAND_TIMEOUT(LAND), .SCORE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en),
    .btn_left(btn_left), .btn_right(btn_right),
    .next_valid(next_valid), .next_side(next_side), .landed(landed),
    .jump_left(jump_left), .jump_right(jump_right), .jump_fail(jump_fail),
    .block_advance(block_advance), .busy(busy), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] at;
    logic [9:0]  score;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  m_score = 0;
  int  m_wait = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input logic [2:0] k, input int at, input int sc);
    ev_t e;
    e.kind  = k;
    e.at    = 32'(at);
    e.score = 10'(sc);
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: actual kind=%0d at cycle %0d, required no event", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, int'(e.kind));
      chk("event_cycle", cyc, int'(e.at));
      chk("event_score", int'(score), int'(e.score));
      chk("event_busy", int'(busy), (kind < 3) ? 1 : 0);
    end
  endtask

  // Monitor: every command, advance and game-over rise must match the queue head.
  logic go_prev = 1'b0;
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      logic seen;
      case (k)
        0:       seen = jump_left;
        1:       seen = jump_right;
        2:       seen = jump_fail;
        3:       seen = block_advance;
        default: seen = game_over & ~go_prev;
      endcase
      if (seen === 1'b1) check_event(k);
    end
    go_prev <= game_over;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    module_en = 1'b1;
    btn_left = 1'b0;
    btn_right = 1'b0;
    landed = 1'b0;
    next_valid = 1'b0;
    step(2);
    rst = 1'b0;
    m_score = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_jump_left"}, int'(jump_left), 0);
    chk({tag, "_jump_right"}, int'(jump_right), 0);
    chk({tag, "_jump_fail"}, int'(jump_fail), 0);
    chk({tag, "_block_advance"}, int'(block_advance), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
  endtask

  // One press followed by landed land_dly cycles later.
  task automatic jump(input int side, input int correct, input int gap, input int land_dly);
    int c;
    int d;
    logic r;
    next_valid = 1'b1;
    next_side = side[0];
    step(gap);
    r = correct[0] ? side[0] : ~side[0];
    btn_right = r;
    btn_left = ~r;
    c = cyc;
    push_ev(correct[0] ? (side[0] ? K_JR : K_JL) : K_JF, c + 1, m_score);
    step(1);
    btn_left = 1'b0;
    btn_right = 1'b0;
    step(land_dly - 1);
    landed = 1'b1;
    d = cyc;
    if (correct[0]) begin
      m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
      push_ev(K_ADV, d + 1, m_score);
      m_wait = d + 1;
    end else begin
      push_ev(K_OVER, d + 1, m_score);
    end
    step(1);
    landed = 1'b0;
  endtask

  task automatic ignored_inputs(input int n);
    repeat (n) begin
      btn_left = 1'($urandom_range(0, 1));
      btn_right = 1'($urandom_range(0, 1));
      landed = 1'($urandom_range(0, 1));
      next_side = 1'($urandom_range(0, 1));
      next_valid = 1'b1;
      step(1);
    end
    btn_left = 1'b0;
    btn_right = 1'b0;
    landed = 1'b0;
    step(1);
    chk("game_over_sticky", int'(game_over), 1);
  endtask

  initial begin
    int c;
    int fr;
    int sc_keep;

    do_reset();
    check_idle("reset");

    // correct jump then a random run of correct jumps
    jump(1, 1, 2, 10);
    chk("score_first", int'(score), 1);
    chk("busy_after_land", int'(busy), 0);
    repeat (30) jump($urandom_range(0, 1), 1, $urandom_range(0, 4), $urandom_range(1, 40));

    // held button: one command only
    next_valid = 1'b1;
    next_side = 1'b1;
    btn_right = 1'b1;
    c = cyc;
    push_ev(K_JR, c + 1, m_score);
    step(5);
    landed = 1'b1;
    m_score++;
    push_ev(K_ADV, cyc + 1, m_score);
    m_wait = cyc + 1;
    step(1);
    landed = 1'b0;
    step(14);
    btn_right = 1'b0;
    step(1);

    // reaction expiry, delayed by a next_valid=0 window containing a press
    fr = $urandom_range(6, 20);
    push_ev(K_JF, m_wait + REACT + fr, m_score);
    push_ev(K_OVER, m_wait + REACT + fr + LAND, m_score);
    next_valid = 1'b0;
    step(2);
    btn_left = 1'b1;
    step(2);
    btn_left = 1'b0;
    step(fr - 4);
    next_valid = 1'b1;
    step(m_wait + REACT + fr + LAND + 3 - cyc);
    ignored_inputs(20);

    // wrong side
    do_reset();
    jump(0, 0, 1, 7);
    step(2);
    ignored_inputs(15);

    // landing watchdog with late landed
    do_reset();
    jump(1, 1, 1, 5);
    next_side = 1'b0;
    btn_left = 1'b1;
    c = cyc;
    push_ev(K_JL, c + 1, m_score);
    push_ev(K_OVER, c + 1 + LAND, m_score);
    step(1);
    btn_left = 1'b0;
    step(c + LAND + 5 - cyc);
    landed = 1'b1;
    step(1);
    landed = 1'b0;
    step(1);
    chk("watchdog_game_over", int'(game_over), 1);
    chk("watchdog_score", int'(score), m_score);

    // simultaneous presses
    do_reset();
    repeat (3) jump($urandom_range(0, 1), 1, $urandom_range(0, 3), $urandom_range(1, 20));
    btn_left = 1'b1;
    btn_right = 1'b1;
    push_ev(K_JF, cyc + 1, m_score);
    step(1);
    btn_left = 1'b0;
    btn_right = 1'b0;
    step(3);
    landed = 1'b1;
    push_ev(K_OVER, cyc + 1, m_score);
    step(1);
    landed = 1'b0;
    step(2);

    // press in the same cycle as reaction expiry wins
    do_reset();
    jump(0, 1, 1, 4);
    step(m_wait + REACT - 1 - cyc);
    next_side = 1'b1;
    btn_right = 1'b1;
    push_ev(K_JR, cyc + 1, m_score);
    step(1);
    btn_right = 1'b0;
    step(2);
    landed = 1'b1;
    m_score++;
    push_ev(K_ADV, cyc + 1, m_score);
    step(1);
    landed = 1'b0;

    // button held through reset gives one edge on the first enabled cycle
    rst = 1'b1;
    next_valid = 1'b1;
    next_side = 1'b1;
    btn_right = 1'b1;
    step(2);
    rst = 1'b0;
    m_score = 0;
    push_ev(K_JR, cyc + 1, m_score);
    step(1);
    btn_right = 1'b0;
    step(1);
    landed = 1'b1;
    m_score = 1;
    push_ev(K_ADV, cyc + 1, m_score);
    step(1);
    landed = 1'b0;

    // saturation
    do_reset();
    for (int i = 0; i < SMAX + 1; i++)
      jump($urandom_range(0, 1), 1, $urandom_range(0, 2), $urandom_range(1, 3));
    chk("score_saturated", int'(score), SMAX);

    // module_en low mid-jump
    sc_keep = m_score;
    next_valid = 1'b1;
    next_side = 1'b1;
    btn_right = 1'b1;
    push_ev(K_JR, cyc + 1, sc_keep);
    step(1);
    btn_right = 1'b0;
    step(1);
    module_en = 1'b0;
    step(1);
    check_idle("en_low");
    module_en = 1'b1;
    step(1);
    chk("reenable_busy", int'(busy), 0);
    m_score = 0;
    jump(0, 1, 1, 3);
    chk("reenable_score", int'(score), 1);

    step(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jump_controller.md
# jump_controller

Game-side command issuer for the jumping character. Turns player button presses and the side of the next platform block into one-cycle `jump_left` / `jump_right` / `jump_fail` commands for the character module. It then waits for the character's `landed` pulse and updates the score. It also tells the block generator to advance and latches game over.

## Interface

**Parameters**

- `CNT_W`, default 26: width of the reaction and landing counters.
- `REACT_CYCLES`, default 40_000_000: clock cycles allowed for a press (1 s at 40 MHz).
- `LAND_TIMEOUT`, default 20_000_000: maximum cycles from a command to `landed` (covers the 15.7 M-cycle fall).
- `SCORE_MAX`, default 999: score saturation value.

**Ports**

- `clk` in 1: 40 MHz system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `module_en` in 1: low acts exactly as `rst` (game not running).
- `btn_left` in 1: debounced level, player left.
- `btn_right` in 1: debounced level, player right.
- `next_valid` in 1: next block side is known.
- `next_side` in 1: side of the next block, 0 = left, 1 = right.
- `landed` in 1: one-cycle pulse from the character.
- `jump_left` out 1: one-cycle command pulse.
- `jump_right` out 1: one-cycle command pulse.
- `jump_fail` out 1: one-cycle command pulse.
- `block_advance` out 1: one-cycle pulse after a successful landing.
- `busy` out 1: a command is outstanding.
- `score` out 10: successful jumps, saturating at `SCORE_MAX`.
- `game_over` out 1: sticky until reset.

## Operation

**States:** `S_WAIT` (reset state), `S_JUMP`, `S_FALL`, `S_OVER`.

**Press detection**
- Edge detection: `btn_*_q` registers hold the previous level. `press_l = btn_left & ~btn_left_q`, and likewise `press_r`.
- Button registers clear to 0 on reset, so a button held through reset produces one edge on the first enabled cycle.

**S_WAIT**
- If `next_valid` = 0, presses are ignored and the reaction counter holds.
- Single press matching `next_side` → pulse `jump_left` or `jump_right` → `S_JUMP`. Sets `started`.
- Single press on the wrong side → pulse `jump_fail` → `S_FALL`.
- `press_l` and `press_r` in the same cycle → `jump_fail` → `S_FALL`.
- Reaction counter:
  - Runs only when `started` = 1 and `next_valid` = 1.
  - Clears on every transition into `S_WAIT`.
  - On reaching `REACT_CYCLES-1` with no press → `jump_fail` → `S_FALL`.
  - If a press and expiry occur in the same cycle, the press wins.

**S_JUMP**
- Landing counter counts from 0.
- `landed` → pulse `block_advance`, `score` +1 (held at `SCORE_MAX`) → `S_WAIT`.
- Counter reaching `LAND_TIMEOUT-1` without `landed` → `S_OVER`, no score change.

**S_FALL**
- `landed` or timeout → `S_OVER`.

**S_OVER**
- `game_over` = 1. All presses and `landed` are ignored until `rst` or `module_en` = 0.

**General rules**
- A `landed` pulse arriving in `S_WAIT` or `S_OVER` is ignored; it does not change the score.
- At most one command is outstanding. Exactly one of the three command outputs pulses per transition out of `S_WAIT`.
- `busy` = 1 in `S_JUMP` and `S_FALL`.

## Timing

- **Reset values:** all outputs 0. State `S_WAIT`, `started` 0, both counters 0.
- **Press to command:** buttons sampled at edge N; the command pulse is high for exactly the cycle after edge N, and `busy` rises on that same cycle. Latency is 1 cycle, all outputs registered.
- **Landing:** `landed` sampled at edge M → `block_advance` high and `score` updated during the cycle after M; state is `S_WAIT` on that cycle.
- **Back-to-back jumps:** a press is accepted as early as the cycle in which `block_advance` is high.
- **Timeout:** `game_over` rises on the cycle after the counter reaches `LAND_TIMEOUT-1`.
- **Reset mid-jump:** `rst` or `module_en` = 0 clears everything on the next edge. The character resets under the same condition, so no command is left outstanding.

## Test plan

Benches use `REACT_CYCLES`=100 and `LAND_TIMEOUT`=50.

- **Correct jump:** `next_side`=1, rise `btn_right` → `jump_right` is a 1-cycle pulse on the next cycle. Then `landed` 10 cycles later → `block_advance` 1-cycle pulse, `score` 0→1, `busy` low.
- **Wrong side:** `next_side`=0, press right → `jump_fail` pulse, then `landed` → `game_over`=1 with `score` unchanged. Further presses produce no pulses.
- **Reaction timeout:** after one successful jump, no press for 100 cycles → `jump_fail` exactly 100 cycles after entering `S_WAIT`. A press with `next_valid`=0 does nothing and freezes the counter.
- **Landing watchdog:** jump issued, `landed` withheld → `game_over`=1 on cycle 50 after the command, `score` unchanged. A late `landed` is ignored.
- **Simultaneous and held inputs:** both buttons rise together → `jump_fail`. A button held high for 20 cycles yields only one command. A press in the same cycle as reaction expiry issues the jump, not `jump_fail`.
- **Saturation and enable:**
  - Preload via 999 successful jumps; jump 1000 → `score` stays 999.
  - `module_en` low during `S_JUMP` → all outputs 0 next cycle; re-enabling starts in `S_WAIT`.
